// File: rtl/mesh_term_rx.sv
// Terminal receiver: drains a mesh router output port, keeps packets addressed to this node or broadcast.
// Latency: pop one cycle after pndng is seen; rx_valid one cycle after pop; at most 1 packet per 3 cycles.
// Backpressure: a full local FIFO holds off popping; pndng may stay high indefinitely. Optional RX_STATS_EN adds counters.

module mesh_term_rx_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] full_cnt = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  logic          rd_en;

  assign rd_en = rd_vld && rd_rdy;

  always_comb begin
    cnt_nxt = cnt;
    if (wr_vld && !rd_en)
      cnt_nxt = cnt + 1'b1;
    else if (!wr_vld && rd_en)
      cnt_nxt = cnt - 1'b1;
  end

  // When full, a concurrent write lands on the slot being read out, which is safe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rd_vld <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wr_vld) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      cnt    <= cnt_nxt;
      rd_vld <= (cnt_nxt != '0);
    end
  end

  assign rd_dat = mem[rd_ptr];
  assign full   = (cnt == full_cnt);
endmodule

module mesh_term_rx #(
  parameter int         pckg_sz    = 32,
  parameter int         fifo_depth = 4,
  parameter logic [7:0] bdcst      = 8'hFF,
  parameter logic [3:0] id_row     = 4'd0,
  parameter logic [3:0] id_column  = 4'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [pckg_sz-18:0] rx_data,
  output logic               rx_mode,
  output logic               rx_bcst,
  output logic               err_misroute,
  output logic [15:0]        rx_pkt_cnt,
  output logic [15:0]        drop_cnt
);
  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                cap_en;
  logic [pckg_sz-9:0]  cap;
  logic [7:0]          dest;
  logic                is_bcst;
  logic                is_local;
  logic                fifo_wr;
  logic                drop;
  logic                fifo_full;
  logic [pckg_sz-16:0] wr_entry;
  logic [pckg_sz-16:0] head;
  logic                unused_nxt_jump;

  // Next-jump byte is routing state for the router only.
  assign unused_nxt_jump = ^data_out[pckg_sz-1:pckg_sz-8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cap_en    = 1'b0;
    case (state)
      IDLE: begin
        if (pndng && !fifo_full) begin
          cap_en    = 1'b1;
          state_nxt = POP;
        end
      end
      POP: begin
        pop       = 1'b1;
        state_nxt = SETTLE;
      end
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cap <= '0;
    else if (cap_en)
      cap <= data_out[pckg_sz-9:0];
  end

  assign dest     = cap[pckg_sz-9:pckg_sz-16];
  assign is_bcst  = (dest == bdcst);
  assign is_local = (dest == {id_row, id_column});
  assign fifo_wr  = pop && (is_bcst || is_local);
  assign drop     = pop && !(is_bcst || is_local);
  assign wr_entry = {is_bcst, cap[pckg_sz-17:0]};

  mesh_term_rx_fifo #(
    .W     (pckg_sz - 15),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (fifo_wr),
    .wr_dat (wr_entry),
    .rd_vld (rx_valid),
    .rd_rdy (rx_ready),
    .rd_dat (head),
    .full   (fifo_full)
  );

  assign {rx_bcst, rx_mode, rx_data} = head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_misroute <= 1'b0;
    else if (drop)
      err_misroute <= 1'b1;
  end

`ifdef RX_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_pkt_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (fifo_wr && rx_pkt_cnt != 16'hFFFF)
        rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
      if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign rx_pkt_cnt = '0;
  assign drop_cnt   = '0;
`endif
endmodule

// File: tb/tb_mesh_term_rx.sv
// Directed bench for mesh_term_rx at id (1,0), 32-bit packets, 4-deep FIFO, with a queue-based router model.
module tb_mesh_term_rx;
  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  logic [31:0] data_out;
  logic        pop;
  logic        rx_valid;
  logic        rx_ready;
  logic [14:0] rx_data;
  logic        rx_mode;
  logic        rx_bcst;
  logic        err_misroute;
  logic [15:0] rx_pkt_cnt;
  logic [15:0] drop_cnt;

`ifdef RX_STATS_EN
  localparam bit stats = 1'b1;
`else
  localparam bit stats = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int pop_n  = 0;
  int consec = 0;
  logic pop_d;
  logic last_pop = 1'b0;
  logic [31:0] rq[$];
  logic [16:0] got[$];
  int pop_at[$];

  mesh_term_rx #(
    .pckg_sz    (32),
    .fifo_depth (4),
    .bdcst      (8'hFF),
    .id_row     (4'd1),
    .id_column  (4'd0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pndng        (pndng),
    .data_out     (data_out),
    .pop          (pop),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_mode      (rx_mode),
    .rx_bcst      (rx_bcst),
    .err_misroute (err_misroute),
    .rx_pkt_cnt   (rx_pkt_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [3:0] r, input logic [3:0] c,
                                     input logic m, input logic [14:0] pl);
    return {8'h5A, r, c, m, pl};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    pndng    = (rq.size() != 0);
    data_out = (rq.size() != 0) ? rq[0] : 32'h0;
  endtask

  task automatic push(input logic [31:0] p);
    rq.push_back(p);
    drive();
  endtask

  // One clock: record what the DUT shows before the edge, then let the router react to pop.
  task automatic cyc();
    if (rx_valid && rx_ready)
      got.push_back({rx_bcst, rx_mode, rx_data});
    pop_d = pop;
    if (pop) begin
      pop_n++;
      pop_at.push_back(cyc_n);
      if (last_pop) consec++;
    end
    last_pop = pop;
    @(posedge clk);
    #1;
    if (pop_d && rq.size() != 0)
      void'(rq.pop_front());
    drive();
    @(negedge clk);
    cyc_n++;
  endtask

  initial begin
    reset    = 1'b1;
    rx_ready = 1'b0;
    pndng    = 1'b0;
    data_out = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_pop", pop, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_mode", rx_mode, 0);
    chk("rst_rx_bcst", rx_bcst, 0);
    chk("rst_err", err_misroute, 0);
    chk("rst_pkt_cnt", rx_pkt_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    reset = 1'b0;
    cyc();

    // Single unicast to (1,0)
    push(mk(4'd1, 4'd0, 1'b1, 15'h1234));
    chk("uni_pop_pre", pop, 0);
    cyc();
    chk("uni_pop", pop, 1);
    chk("uni_valid_early", rx_valid, 0);
    cyc();
    chk("uni_pop_off", pop, 0);
    chk("uni_valid", rx_valid, 1);
    chk("uni_data", rx_data, 15'h1234);
    chk("uni_mode", rx_mode, 1);
    chk("uni_bcst", rx_bcst, 0);
    chk("uni_pkt_cnt", rx_pkt_cnt, stats ? 1 : 0);
    rx_ready = 1'b1;
    cyc();
    chk("uni_drained", rx_valid, 0);

    // Broadcast
    push(mk(4'hF, 4'hF, 1'b0, 15'h0ABC));
    cyc();
    cyc();
    chk("bc_valid", rx_valid, 1);
    chk("bc_bcst", rx_bcst, 1);
    chk("bc_data", rx_data, 15'h0ABC);
    chk("bc_mode", rx_mode, 0);
    chk("bc_pkt_cnt", rx_pkt_cnt, stats ? 2 : 0);
    repeat (3) cyc();

    // Misroute to (1,1)
    push(mk(4'd1, 4'd1, 1'b1, 15'h0007));
    cyc();
    chk("mis_pop", pop, 1);
    cyc();
    chk("mis_valid", rx_valid, 0);
    chk("mis_err", err_misroute, 1);
    chk("mis_drop_cnt", drop_cnt, stats ? 1 : 0);
    repeat (10) cyc();
    chk("mis_err_sticky", err_misroute, 1);
    chk("mis_valid_late", rx_valid, 0);

    // Backpressure: 6 pending, FIFO holds 4
    rx_ready = 1'b0;
    pop_n = 0;
    got.delete();
    for (int i = 0; i < 6; i++)
      push(mk(4'd1, 4'd0, i[0], 15'h100 + 15'(i)));
    repeat (24) cyc();
    chk("bp_pops", pop_n, 4);
    chk("bp_pop_idle", pop, 0);
    chk("bp_valid", rx_valid, 1);
    chk("bp_head", rx_data, 15'h100);
    rx_ready = 1'b1;
    repeat (30) cyc();
    chk("bp_pops_total", pop_n, 6);
    chk("bp_got_n", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      logic [16:0] e;
      e = got[i];
      chk("bp_order", e[14:0], 15'h100 + 15'(i));
      chk("bp_mode", e[15], i[0]);
    end

    // Throughput: 8 packets back to back
    pop_n = 0;
    pop_at.delete();
    got.delete();
    for (int i = 0; i < 8; i++)
      push(mk(4'd1, 4'd0, 1'b0, 15'h200 + 15'(i)));
    repeat (30) cyc();
    chk("tp_pops", pop_n, 8);
    for (int i = 1; i < pop_at.size(); i++)
      chk("tp_spacing", pop_at[i] - pop_at[i-1], 3);
    chk("tp_got_n", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      logic [16:0] e;
      e = got[i];
      chk("tp_order", e[14:0], 15'h200 + 15'(i));
    end
    chk("no_consec_pop", consec, 0);

    // Reset while a second packet is in POP, with one packet already held
    rx_ready = 1'b0;
    got.delete();
    push(mk(4'd1, 4'd0, 1'b0, 15'h03AA));
    repeat (3) cyc();
    chk("rst_pre_valid", rx_valid, 1);
    push(mk(4'd1, 4'd0, 1'b0, 15'h03BB));
    for (int i = 0; i < 10 && !pop; i++) cyc();
    chk("rst_in_pop", pop, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_pop", pop, 0);
    chk("rst_mid_valid", rx_valid, 0);
    cyc();
    reset = 1'b0;
    rx_ready = 1'b1;
    repeat (8) cyc();
    chk("rst_after_n", got.size(), 1);
    if (got.size() != 0) begin
      logic [16:0] e;
      e = got[0];
      chk("rst_after_data", e[14:0], 15'h03BB);
    end
    chk("rst_after_err", err_misroute, 0);
    chk("rst_after_cnt", rx_pkt_cnt, stats ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
